// File: rtl/glitch_sequencer_pkg.sv
// Shared types and constants for the glitch sequencer.
// Optional feature macro: GLITCH_TRIG_SYNC_EN (see glitch_trig_detect).
package glitch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DELAY   = 3'd1,
        S_GLITCH  = 3'd2,
        S_GAP     = 3'd3,
        S_HOLDOFF = 3'd4
    } gs_state_e;

    localparam int unsigned HOLDOFF_DEFAULT = 32'd50_000_000;

endpackage

// File: rtl/glitch_sequencer_if.sv
// Trigger/config/status bundle between the host side (master) and the sequencer (slave).
interface glitch_sequencer_if #(
    parameter int CNT_W   = 32,
    parameter int WIDTH_W = 8,
    parameter int REP_W   = 4
);
    logic               trig;
    logic               abort;
    logic [CNT_W-1:0]   delay_cfg;
    logic [WIDTH_W-1:0] width_cfg;
    logic [REP_W-1:0]   repeat_cfg;
    logic [CNT_W-1:0]   gap_cfg;
    logic               glitch_n;
    logic               busy;
    logic               in_holdoff;
    logic               done;

    modport master (
        output trig, abort, delay_cfg, width_cfg, repeat_cfg, gap_cfg,
        input  glitch_n, busy, in_holdoff, done
    );

    modport slave (
        input  trig, abort, delay_cfg, width_cfg, repeat_cfg, gap_cfg,
        output glitch_n, busy, in_holdoff, done
    );
endinterface

// File: rtl/glitch_sequencer_trig_detect.sv
// Trigger rising-edge detector; with GLITCH_TRIG_SYNC_EN defined, trig first
// passes a two-flop synchroniser (adds two cycles of latency).
module glitch_trig_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    output logic rise_o
);
    logic trig_s;
    logic trig_q;

`ifdef GLITCH_TRIG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], trig_i};
    end

    assign trig_s = sync_q[1];
`else
    assign trig_s = trig_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_q <= 1'b0;
        else        trig_q <= trig_s;
    end

    assign rise_o = trig_s & ~trig_q;
endmodule

// File: rtl/glitch_sequencer.sv
// Triggerable glitch pulse burst generator with active-low registered output.
// Optional macro GLITCH_TRIG_SYNC_EN adds a trigger synchroniser in glitch_trig_detect.
//
// state     | meaning
// S_IDLE    | armed, waiting for a trigger rise
// S_DELAY   | counting the pre-delay before the first pulse
// S_GLITCH  | glitch output low for 2*width+1 cycles
// S_GAP     | output high for gap+1 cycles between pulses
// S_HOLDOFF | fixed dead time after the burst before re-arming
module glitch_sequencer
    import glitch_sequencer_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int          WIDTH_W = 8,
    parameter int          REP_W   = 4,
    parameter int unsigned HOLDOFF = HOLDOFF_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    glitch_sequencer_if.slave gif
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    gs_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REP_W-1:0]   pulse_q, pulse_d;
    logic [CNT_W-1:0]   delay_q, gap_q;
    logic [WIDTH_W-1:0] width_q;
    logic [REP_W-1:0]   rep_q;
    logic               glitch_n_q, glitch_n_d;
    logic               busy_q, busy_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               rise;
    logic               load;
    logic [CNT_W-1:0]   delay_last;
    logic [CNT_W-1:0]   pulse_last;

    glitch_trig_detect u_trig (
        .clk    (clk),
        .rst_n  (rst_n),
        .trig_i (gif.trig),
        .rise_o (rise)
    );

    assign load       = (state_q == S_IDLE) && rise && !gif.abort;
    assign delay_last = delay_q - 1'b1;
    // Width is widened before doubling so the top bit is never lost.
    assign pulse_last = CNT_W'({width_q, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pulse_q    <= '0;
            delay_q    <= '0;
            gap_q      <= '0;
            width_q    <= '0;
            rep_q      <= '0;
            glitch_n_q <= 1'b1;
            busy_q     <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
            glitch_n_q <= glitch_n_d;
            busy_q     <= busy_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            if (load) begin
                delay_q <= gif.delay_cfg;
                gap_q   <= gif.gap_cfg;
                width_q <= gif.width_cfg;
                rep_q   <= gif.repeat_cfg;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    cnt_d   = '0;
                    pulse_d = '0;
                    state_d = (gif.delay_cfg == '0) ? S_GLITCH : S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt_q == delay_last) begin
                    cnt_d   = '0;
                    state_d = S_GLITCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GLITCH: begin
                if (cnt_q == pulse_last) begin
                    cnt_d = '0;
                    if (pulse_q == rep_q) begin
                        state_d = S_HOLDOFF;
                    end else begin
                        pulse_d = pulse_q + 1'b1;
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == gap_q) begin
                    cnt_d   = '0;
                    state_d = S_GLITCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides every transition, including a same-cycle trigger.
        if (gif.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pulse_d = '0;
        end
    end

    always_comb begin
        glitch_n_d = (state_d != S_GLITCH);
        busy_d     = (state_d != S_IDLE);
        hold_d     = (state_d == S_HOLDOFF);
        done_d     = (state_q == S_HOLDOFF) && (state_d == S_IDLE) && !gif.abort;
    end

    assign gif.glitch_n   = glitch_n_q;
    assign gif.busy       = busy_q;
    assign gif.in_holdoff = hold_q;
    assign gif.done       = done_q;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_glitch_sequencer;
    localparam int CNT_W   = 32;
    localparam int WIDTH_W = 8;
    localparam int REP_W   = 4;
    localparam int HOLD    = 20;
`ifdef GLITCH_TRIG_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int K_G = 0, K_B = 1, K_H = 2, K_D = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    glitch_sequencer_if #(.CNT_W(CNT_W), .WIDTH_W(WIDTH_W), .REP_W(REP_W)) gif ();

    glitch_sequencer #(
        .CNT_W   (CNT_W),
        .WIDTH_W (WIDTH_W),
        .REP_W   (REP_W),
        .HOLDOFF (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gif   (gif)
    );

    typedef struct {
        int   kind;
        logic val;
        int   cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic prev[4];
    logic cur[4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_G:     return "glitch_n";
            K_B:     return "busy";
            K_H:     return "in_holdoff";
            default: return "done";
        endcase
    endfunction

    task automatic push(int k, logic v, int c);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(int k, logic v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %s=%0b @cycle %0d, required none", kname(k), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v || e.cyc != cyc) begin
                n_err++;
                $display("FAIL event: got %s=%0b @cycle %0d, required %s=%0b @cycle %0d",
                         kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur[K_G] = gif.glitch_n;
            cur[K_B] = gif.busy;
            cur[K_H] = gif.in_holdoff;
            cur[K_D] = gif.done;
            for (int k = 0; k < 4; k++) begin
                if ((k == K_D) ? (cur[k] === 1'b1) : (cur[k] !== prev[k]))
                    check_ev(k, cur[k]);
                prev[k] = cur[k];
            end
        end
    end

    task automatic direct(string name, logic act, logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    // Expected events for one full burst whose rise is sampled at edge n; returns the IDLE edge.
    task automatic exp_burst(int n, int d, int w, int r, int g, output int fin);
        int t;
        int rs;
        t = n + d;
        rs = 0;
        if (d == 0) begin
            push(K_G, 1'b0, n);
            push(K_B, 1'b1, n);
        end else begin
            push(K_B, 1'b1, n);
            push(K_G, 1'b0, t);
        end
        for (int p = 0; p <= r; p++) begin
            if (p > 0) push(K_G, 1'b0, t);
            rs = t + 2 * w + 1;
            push(K_G, 1'b1, rs);
            if (p < r) t = rs + g + 1;
        end
        push(K_H, 1'b1, rs);
        fin = rs + HOLD;
        push(K_B, 1'b0, fin);
        push(K_H, 1'b0, fin);
        push(K_D, 1'b1, fin);
    endtask

    task automatic cfg(int d, int w, int r, int g);
        gif.delay_cfg  = CNT_W'(d);
        gif.width_cfg  = WIDTH_W'(w);
        gif.repeat_cfg = REP_W'(r);
        gif.gap_cfg    = CNT_W'(g);
    endtask

    task automatic fire(output int n);
        @(negedge clk);
        gif.trig = 1'b1;
        n = cyc + 1 + LAT;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fin;
        gif.trig  = 1'b0;
        gif.abort = 1'b0;
        cfg(0, 0, 0, 0);
        prev[K_G] = 1'b1;
        prev[K_B] = 1'b0;
        prev[K_H] = 1'b0;
        prev[K_D] = 1'b0;

        #12;
        direct("reset_glitch_n", gif.glitch_n, 1'b1);
        direct("reset_busy", gif.busy, 1'b0);
        direct("reset_in_holdoff", gif.in_holdoff, 1'b0);
        direct("reset_done", gif.done, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Single 7-cycle pulse, no delay.
        cfg(0, 3, 0, 0);
        fire(n);
        exp_burst(n, 0, 3, 0, 0, fin);
        repeat (3) @(negedge clk);
        gif.trig = 1'b0;
        wait_until(fin + 4);

        // Delayed triple burst; config changed mid-burst must be ignored.
        cfg(10, 0, 2, 4);
        fire(n);
        exp_burst(n, 10, 0, 2, 4, fin);
        @(negedge clk);
        cfg(1, 7, 0, 9);
        gif.trig = 1'b0;
        wait_until(fin + 4);

        // Trigger held high, then a fresh rise during holdoff: one burst only.
        cfg(2, 1, 1, 0);
        fire(n);
        exp_burst(n, 2, 1, 1, 0, fin);
        wait_until(n + 12);
        gif.trig = 1'b0;
        wait_until(n + 15);
        gif.trig = 1'b1;
        wait_until(fin + 5);
        gif.trig = 1'b0;
        wait_until(fin + 8);

        // Abort in the third cycle of an 11-cycle pulse.
        cfg(0, 5, 0, 0);
        fire(n);
        push(K_G, 1'b0, n);
        push(K_B, 1'b1, n);
        push(K_G, 1'b1, n + 3);
        push(K_B, 1'b0, n + 3);
        wait_until(n + 2);
        gif.abort = 1'b1;
        @(negedge clk);
        gif.abort = 1'b0;
        gif.trig  = 1'b0;
        wait_until(n + 3 + HOLD + 5);

        // Abort coinciding with the trigger rise: nothing starts.
        cfg(0, 0, 0, 0);
        @(negedge clk);
        gif.trig = 1'b1;
        repeat (LAT) @(negedge clk);
        gif.abort = 1'b1;
        @(negedge clk);
        gif.abort = 1'b0;
        repeat (10) @(negedge clk);
        gif.trig = 1'b0;
        repeat (4) @(negedge clk);

        // Maximum repeat count: 16 one-cycle pulses.
        cfg(0, 0, 15, 0);
        fire(n);
        exp_burst(n, 0, 0, 15, 0, fin);
        @(negedge clk);
        gif.trig = 1'b0;
        wait_until(fin + 4);

        // Asynchronous reset in the middle of a pulse.
        cfg(0, 5, 0, 0);
        fire(n);
        push(K_G, 1'b0, n);
        push(K_B, 1'b1, n);
        push(K_G, 1'b1, n + 2);
        push(K_B, 1'b0, n + 2);
        wait_until(n + 1);
        #2;
        rst_n    = 1'b0;
        gif.trig = 1'b0;
        #1;
        direct("async_reset_glitch_n", gif.glitch_n, 1'b1);
        direct("async_reset_busy", gif.busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        mon_en = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Parametrised, triggerable fault-injection pulse generator driving an active-low glitch output, e.g. a supply crowbar. A rising edge on a trigger starts a programmable pre-delay, then a burst of 1..2^REP_W glitch pulses of programmable width separated by programmable gaps, then a fixed holdoff before re-arming. Sits between board inputs (button/switches or a host register block) and the glitch output pin. Status outputs drive LEDs.

Parameters:
CNT_W, 32, width of delay_cfg, gap_cfg and the internal counter.
WIDTH_W, 8, width of width_cfg.
REP_W, 4, width of repeat_cfg.
HOLDOFF, 50000000, holdoff length in clk cycles after a burst. Must be >=1 and < 2^CNT_W.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
trig  in  1  trigger level; a rising edge starts a burst
abort  in  1  synchronous abort, active-high
delay_cfg  in  CNT_W  cycles from trigger detect to first pulse
width_cfg  in  WIDTH_W  pulse width code; each pulse is 2*width_cfg+1 cycles low
repeat_cfg  in  REP_W  pulse count minus 1
gap_cfg  in  CNT_W  high gap between pulses, in cycles minus 1
glitch_n  out  1  glitch output, low = glitch asserted (registered)
busy  out  1  high in any state other than IDLE (registered)
in_holdoff  out  1  high in HOLDOFF (registered)
done  out  1  one-cycle pulse on the HOLDOFF->IDLE transition (registered)

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE, glitch_n=1, busy=0, in_holdoff=0, done=0, counter=0, pulse counter=0, trig history=0.
- Edge detect:
  - trig_q is trig registered (or the synchronised trig, see feature).
  - A rise is trig_s=1 while trig_q=0.
  - A level held high does not retrigger.
- Latching: on an accepted rise, delay_cfg, width_cfg, repeat_cfg and gap_cfg are latched. Config changes mid-burst have no effect.
- States and transitions:
  - IDLE:
    - Rise with delay_cfg=0 -> GLITCH.
    - Rise with delay_cfg!=0 -> DELAY.
    - Rises in any other state are ignored.
  - DELAY: counts delay_cfg cycles, then -> GLITCH.
  - GLITCH: glitch_n=0 for exactly 2*width_cfg+1 cycles.
    - If pulses issued < repeat_cfg+1 -> GAP.
    - Otherwise -> HOLDOFF.
  - GAP: glitch_n=1 for gap_cfg+1 cycles, then -> GLITCH.
  - HOLDOFF: glitch_n=1 for HOLDOFF cycles, then -> IDLE with done=1 for that one cycle.
- Latency: with no sync, the rise is sampled at edge N and glitch_n falls at edge N+delay_cfg. Every output is a register updated on the same edge as the state.
- Widths:
  - width_cfg is zero-extended before the shift, so the shift never truncates.
  - The counter compares with ==; reaching the terminal value reloads it to 0.
  - width_cfg=0 gives a 1-cycle pulse.
  - repeat_cfg=2^REP_W-1 gives 2^REP_W pulses.
- abort (priority over all transitions except reset): next edge forces state=IDLE, glitch_n=1, counters=0, done=0. HOLDOFF is skipped.
- abort and trigger rise in the same IDLE cycle: abort wins and no burst starts.
- Reset mid-pulse: glitch_n returns to 1 immediately (asynchronous).

Optional Feature:
GLITCH_TRIG_SYNC_EN:
- When defined, trig passes through a two-flop synchroniser before edge detect, adding 2 cycles of latency (glitch_n falls at N+2+delay_cfg). Synchroniser flops reset to 0.
- When undefined, trig feeds edge detect directly and must be synchronous to clk.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=0, DELAY=1, GLITCH=2, GAP=3, HOLDOFF=4 (3 bits)
  - default HOLDOFF constant
- One natural sub-module, glitch_trig_detect: optional synchroniser plus rising-edge detector, outputting a single-cycle rise pulse.
- FSM, counters and output registers stay in glitch_sequencer.

Test Plan:
- delay=0, width=3, repeat=0, HOLDOFF=20 (overridden), trig 0->1 -> glitch_n low exactly 7 cycles from the rise edge, busy high, in_holdoff high 20 cycles, done pulses once, busy falls.
- delay=10, width=0, repeat=2, gap=4 -> pulse pattern 1 low / 5 high / 1 low / 5 high / 1 low; first fall 10 cycles after the rise.
- trig held high through and past the burst, plus a second rise during HOLDOFF -> no retrigger; exactly one burst.
- abort asserted in the 3rd cycle of a width=5 pulse -> glitch_n=1 and busy=0 on the next edge; done stays 0.
- rst_n low mid-GLITCH -> glitch_n=1 and busy=0 immediately, without waiting for a clk edge.
- Build with GLITCH_TRIG_SYNC_EN, delay=0 -> glitch_n falls 2 cycles later than in the first scenario.
